// File: rtl/vga_plot_arbiter_if.sv
// rtl/vga_plot_arbiter_if.sv - request/engine/adapter bundle for the VGA plot arbiter
// slave is the arbiter's view; master is the task top level / engines side.
interface vga_plot_arbiter_if #(
    parameter int N_ENG = 3
);
    logic [N_ENG-1:0]   req;
    logic [N_ENG-1:0]   ack;
    logic [N_ENG-1:0]   eng_start;
    logic [N_ENG-1:0]   eng_done;
    logic [8*N_ENG-1:0] eng_x;
    logic [7*N_ENG-1:0] eng_y;
    logic [3*N_ENG-1:0] eng_colour;
    logic [N_ENG-1:0]   eng_plot;
    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [2:0]         vga_colour;
    logic               vga_plot;
    logic               busy;
    logic [2:0]         grant_id;

    modport slave (
        input  req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        output ack, eng_start, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id
    );

    modport master (
        output req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        input  ack, eng_start, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin owner of the single VGA adapter plot port
// One engine runs at a time; its plot bus is muxed straight through to the adapter.
module vga_plot_arbiter #(
    parameter int N_ENG = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_plot_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE
    } state_t;

    localparam logic [N_ENG-1:0] ONE = {{(N_ENG-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [2:0]       r_grant;
    logic [2:0]       r_last;
    logic [N_ENG-1:0] r_ack;
    logic [N_ENG-1:0] r_eng_start;
    logic             r_busy;

    logic             w_found;
    logic [2:0]       w_pick;
    logic [3:0]       w_sum;
    logic [2:0]       w_idx;
    logic [N_ENG-1:0] w_gmask;
    logic             w_done_g;
    logic             w_plot_g;
    logic [7:0]       w_sel_x;
    logic [6:0]       w_sel_y;
    logic [2:0]       w_sel_colour;

    // Search last+1, last+2, ... wrapping; last < N_ENG so one subtraction is a full modulo.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_sum   = 4'd0;
        w_idx   = 3'd0;
        for (int k = 1; k <= N_ENG; k++) begin
            w_sum = 4'(r_last) + 4'(k);
            w_idx = 3'((w_sum >= 4'(N_ENG)) ? (w_sum - 4'(N_ENG)) : w_sum);
            if (!w_found && (|(bus.req & (ONE << w_idx)))) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_gmask  = ONE << r_grant;
    assign w_done_g = |(bus.eng_done & w_gmask);
    assign w_plot_g = |(bus.eng_plot & w_gmask);

    always_comb begin
        w_sel_x      = 8'd0;
        w_sel_y      = 7'd0;
        w_sel_colour = 3'd0;
        for (int i = 0; i < N_ENG; i++) begin
            if (r_grant == 3'(i)) begin
                w_sel_x      = bus.eng_x[8*i +: 8];
                w_sel_y      = bus.eng_y[7*i +: 7];
                w_sel_colour = bus.eng_colour[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'd0;
            r_last      <= 3'(N_ENG - 1);
            r_ack       <= '0;
            r_eng_start <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_pick;
                        r_last      <= w_pick;
                        r_eng_start <= ONE << w_pick;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_done_g) begin
                        r_ack       <= w_gmask;
                        r_eng_start <= '0;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Wait for the engine to drop done so its next start is a clean edge.
                    if (!w_done_g) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_eng_start <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.eng_start  = r_eng_start;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant;
    assign bus.vga_plot   = (r_state == S_RUN) && w_plot_g;
    assign bus.vga_x      = (r_state != S_IDLE) ? w_sel_x      : 8'd0;
    assign bus.vga_y      = (r_state != S_IDLE) ? w_sel_y      : 7'd0;
    assign bus.vga_colour = (r_state != S_IDLE) ? w_sel_colour : 3'd0;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [N-1:0]   req = '0;
    logic [N-1:0]   eng_done = '0;
    logic [N-1:0]   eng_plot = '0;
    logic [8*N-1:0] ex = '0;
    logic [7*N-1:0] ey = '0;
    logic [3*N-1:0] ec = '0;

    vga_plot_arbiter_if #(.N_ENG(N)) bus();

    assign bus.req        = req;
    assign bus.eng_done   = eng_done;
    assign bus.eng_plot   = eng_plot;
    assign bus.eng_x      = ex;
    assign bus.eng_y      = ey;
    assign bus.eng_colour = ec;

    vga_plot_arbiter #(.N_ENG(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic set_eng(input int g, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic p, input logic d);
        ex[8*g +: 8] = x;
        ey[7*g +: 7] = y;
        ec[3*g +: 3] = c;
        eng_plot[g]  = p;
        eng_done[g]  = d;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (bus.eng_start === 3'b000 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        ex = 24'hABCDEF; ey = '1; ec = '1; eng_plot = '1; req = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.eng_start !== 3'b000) begin failures++; $display("FAIL reset_start got=%b exp=000", bus.eng_start); end
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b exp=000", bus.ack); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
        checks++; if (bus.vga_plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%b exp=0", bus.vga_plot); end
        checks++; if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin failures++; $display("FAIL reset_vga got=%h/%h/%h exp=0/0/0", bus.vga_x, bus.vga_y, bus.vga_colour); end
        rst_n = 1'b1;
        ex = '0; ey = '0; ec = '0; eng_plot = '0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.eng_start !== 3'b000) begin failures++; $display("FAIL idle_noreq got busy=%b start=%b exp=0/000", bus.busy, bus.eng_start); end
    endtask

    task automatic test_fillscreen();
        int plot_cnt;
        int errs;
        plot_cnt = 0;
        errs = 0;
        req = 3'b001;
        @(negedge clk);
        checks++; if (bus.eng_start !== 3'b001) begin failures++; $display("FAIL fill_start got=%b exp=001", bus.eng_start); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL fill_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.grant_id !== 3'd0) begin failures++; $display("FAIL fill_grant got=%0d exp=0", bus.grant_id); end
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < 120; y++) begin
                set_eng(0, 8'(x), 7'(y), 3'(x), 1'b1, 1'b0);
                #1;
                if (bus.vga_plot === 1'b1) plot_cnt++;
                if (bus.vga_x !== 8'(x) || bus.vga_y !== 7'(y) || bus.vga_colour !== 3'(x)) errs++;
                if (x == 0 && y == 0) begin
                    checks++; if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin failures++; $display("FAIL fill_first got=%0d/%0d/%0d exp=0/0/0", bus.vga_x, bus.vga_y, bus.vga_colour); end
                end
                if (x == 1 && y == 0) begin
                    checks++; if (bus.vga_x !== 8'd1 || bus.vga_colour !== 3'd1) begin failures++; $display("FAIL fill_col1 got x=%0d c=%0d exp=1/1", bus.vga_x, bus.vga_colour); end
                end
                @(negedge clk);
            end
        end
        set_eng(0, 8'd159, 7'd119, 3'd7, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL fill_ack got=%b exp=001", bus.ack); end
        checks++; if (bus.eng_start !== 3'b000 || bus.busy !== 1'b1) begin failures++; $display("FAIL fill_release got start=%b busy=%b exp=000/1", bus.eng_start, bus.busy); end
        set_eng(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        req = 3'b000;
        @(negedge clk);
        checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b0) begin failures++; $display("FAIL fill_end got ack=%b busy=%b exp=000/0", bus.ack, bus.busy); end
        checks++; if (plot_cnt !== 19200) begin failures++; $display("FAIL fill_plots got=%0d exp=19200", plot_cnt); end
        checks++; if (errs !== 0) begin failures++; $display("FAIL fill_track got=%0d exp=0", errs); end
    endtask

    task automatic stub_run(input int g);
        int errs;
        errs = 0;
        wait_start();
        checks++; if (bus.eng_start !== 3'(1 << g) || bus.grant_id !== 3'(g)) begin failures++; $display("FAIL rr_grant got start=%b id=%0d exp id=%0d", bus.eng_start, bus.grant_id, g); end
        for (int p = 0; p < 4; p++) begin
            set_eng(g, 8'(20 + p), 7'(g), 3'(g), 1'b1, 1'b0);
            #1;
            if (bus.vga_plot !== 1'b1 || bus.vga_x !== 8'(20 + p)) errs++;
            @(negedge clk);
        end
        set_eng(g, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (bus.ack !== 3'(1 << g) || bus.eng_start !== 3'b000) begin failures++; $display("FAIL rr_ack got ack=%b start=%b exp eng=%0d", bus.ack, bus.eng_start, g); end
        set_eng(g, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL rr_ack_pulse got=%b exp=000", bus.ack); end
        checks++; if (errs !== 0) begin failures++; $display("FAIL rr_plots got=%0d exp=0", errs); end
    endtask

    task automatic test_round_robin();
        int order [6];
        order = '{1, 2, 0, 1, 2, 0};
        req = 3'b111;
        for (int i = 0; i < 6; i++) stub_run(order[i]);
        req = 3'b000;
        @(negedge clk);
        checks++; if (bus.eng_start !== 3'b000) begin failures++; $display("FAIL rr_stop got=%b exp=000", bus.eng_start); end
    endtask

    task automatic test_ignore_other();
        int errs;
        errs = 0;
        req = 3'b010;
        wait_start();
        checks++; if (bus.eng_start !== 3'b010) begin failures++; $display("FAIL other_start got=%b exp=010", bus.eng_start); end
        for (int c = 0; c < 8; c++) begin
            set_eng(1, 8'd50, 7'd60, 3'd5, (c < 4), 1'b0);
            set_eng(2, 8'd99, 7'd99, 3'd7, c[0], c[0]);
            #1;
            if (bus.vga_x !== 8'd50 || bus.vga_y !== 7'd60 || bus.vga_colour !== 3'd5) errs++;
            if (bus.vga_plot !== (c < 4) || bus.ack !== 3'b000) errs++;
            @(negedge clk);
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL other_isolate got=%0d exp=0", errs); end
        set_eng(1, 8'd50, 7'd60, 3'd5, 1'b0, 1'b1);
        set_eng(2, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        req = 3'b000;
        @(negedge clk);
        checks++; if (bus.ack !== 3'b010) begin failures++; $display("FAIL other_ack got=%b exp=010", bus.ack); end
        set_eng(1, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b0) begin failures++; $display("FAIL other_end got ack=%b busy=%b exp=000/0", bus.ack, bus.busy); end
    endtask

    task automatic test_req_drop();
        int errs;
        errs = 0;
        req = 3'b001;
        wait_start();
        checks++; if (bus.eng_start !== 3'b001) begin failures++; $display("FAIL drop_start got=%b exp=001", bus.eng_start); end
        req = 3'b000;
        set_eng(0, 8'd5, 7'd5, 3'd1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        set_eng(0, 8'd5, 7'd5, 3'd1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL drop_ack got=%b exp=001", bus.ack); end
        set_eng(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            if (bus.eng_start !== 3'b000 || bus.busy !== 1'b0) errs++;
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL drop_norestart got=%0d exp=0", errs); end
    endtask

    task automatic test_done_hold();
        int errs;
        errs = 0;
        req = 3'b011;
        wait_start();
        checks++; if (bus.eng_start !== 3'b010) begin failures++; $display("FAIL hold_start got=%b exp=010", bus.eng_start); end
        set_eng(1, 8'd70, 7'd30, 3'd2, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (bus.ack !== 3'b010 || bus.eng_start !== 3'b000) begin failures++; $display("FAIL hold_zero_work got ack=%b start=%b exp=010/000", bus.ack, bus.eng_start); end
        req = 3'b001;
        for (int i = 0; i < 10; i++) begin
            if (bus.eng_start !== 3'b000 || bus.vga_plot !== 1'b0 || bus.busy !== 1'b1 || bus.vga_x !== 8'd70) errs++;
            @(negedge clk);
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL hold_release got=%0d exp=0", errs); end
        set_eng(1, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.eng_start !== 3'b000) begin failures++; $display("FAIL hold_idle got busy=%b start=%b exp=0/000", bus.busy, bus.eng_start); end
        @(negedge clk);
        checks++; if (bus.eng_start !== 3'b001) begin failures++; $display("FAIL hold_turnaround got=%b exp=001", bus.eng_start); end
        set_eng(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
        req = 3'b000;
        @(negedge clk);
        checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL hold_ack0 got=%b exp=001", bus.ack); end
        set_eng(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        req = 3'b001;
        wait_start();
        checks++; if (bus.eng_start !== 3'b001) begin failures++; $display("FAIL rst_start got=%b exp=001", bus.eng_start); end
        for (int p = 0; p < 50; p++) begin
            set_eng(0, 8'(p), 7'd0, 3'd3, 1'b1, 1'b0);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.eng_start !== 3'b000 || bus.vga_plot !== 1'b0) begin failures++; $display("FAIL rst_async got start=%b plot=%b exp=000/0", bus.eng_start, bus.vga_plot); end
        checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_async_ack got ack=%b busy=%b exp=000/0", bus.ack, bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        set_eng(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        req = 3'b111;
        @(negedge clk);
        checks++; if (bus.eng_start !== 3'b001 || bus.grant_id !== 3'd0) begin failures++; $display("FAIL rst_first got start=%b id=%0d exp=001/0", bus.eng_start, bus.grant_id); end
        set_eng(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        req = 3'b000;
        checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL rst_ack got=%b exp=001", bus.ack); end
        set_eng(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fillscreen();
        test_round_robin();
        test_ignore_other();
        test_req_drop();
        test_done_hold();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA adapter plot port between N drawing engines (fillscreen, circle, line, etc.), each using the start/done handshake and a vga_x/vga_y/vga_colour/vga_plot bus. Grants one engine at a time in round-robin order, drives that engine's start, routes its plot bus to the adapter, and acknowledges the requester when the engine reports done. Sits between the task top level and the VGA adapter instance.

## Interface
- N_ENG, default 3: number of engines/requesters (2..8)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_ENG  per-engine run request; level, held until matching ack
- ack  output  N_ENG  one-cycle pulse when engine i's run completes
- eng_start  output  N_ENG  start to engine i
- eng_done  input  N_ENG  done from engine i
- eng_x  input  8*N_ENG  engine i x at bits [8i+7:8i]
- eng_y  input  7*N_ENG  engine i y at bits [7i+6:7i]
- eng_colour  input  3*N_ENG  engine i colour at bits [3i+2:3i]
- eng_plot  input  N_ENG  engine i plot strobe
- vga_x  output  8  to adapter, 0..159
- vga_y  output  7  to adapter, 0..119
- vga_colour  output  3  to adapter
- vga_plot  output  1  to adapter
- busy  output  1  high in any state except IDLE
- grant_id  output  3  index of current/last granted engine

## Operation
- States: IDLE, RUN, RELEASE. Registers: state, grant (3 bits), last (3 bits).
- IDLE: if req != 0, pick first set bit searching last+1, last+2, … wrapping mod N_ENG; grant <= that index, last <= that index, -> RUN. If req == 0, stay.
- RUN: eng_start[grant] = 1, all other eng_start bits 0. vga_x/y/colour/plot = eng bus slice [grant]. When eng_done[grant] = 1: ack[grant] pulses in this cycle's next-state (registered, high exactly one cycle), -> RELEASE.
- RELEASE: eng_start all 0; vga_plot forced 0; vga_x/y/colour hold granted slice. When eng_done[grant] = 0 -> IDLE. Stays in RELEASE indefinitely while done remains high.
- vga_plot = eng_plot[grant] only in RUN; 0 in IDLE and RELEASE. Plots from non-granted engines never reach the adapter.
- req changes during RUN/RELEASE do not affect the current grant; a requester dropping req mid-run still gets its ack. The arbiter never starts an engine whose req is low at selection time.
- eng_done from a non-granted engine is ignored.
- Indices >= N_ENG never selected.

## Timing
- Reset (async assert): state IDLE, grant 0, last N_ENG-1 (first grant goes to engine 0), ack 0, eng_start 0, vga_plot 0, vga_x 0, vga_y 0, vga_colour 0, busy 0, grant_id 0. Reset mid-run drops eng_start immediately; no ack issued.
- Grant latency: req sampled high in IDLE at edge k -> state RUN and eng_start[g] high after edge k; busy high after edge k.
- Plot path: combinational mux from registered grant; zero added latency from engine bus to adapter.
- Done -> ack: eng_done[g] sampled high at edge m -> ack[g] high for cycle m..m+1, eng_start[g] low after edge m.
- Minimum turnaround: RUN, one RELEASE cycle (engine done falls one cycle after start falls), IDLE one cycle, then next grant: 3 cycles between an engine's done and the next engine's start.
- Simultaneous requests: fairness strictly round-robin from last; an engine cannot be granted twice in a row while another req bit is high.
- Engine that asserts done in the same cycle as start (zero-work run) handled identically: one RUN cycle, ack pulse.

## Test plan
- Reset then req=3'b001, engine 0 = fillscreen: eng_start[0] rises 1 cycle later; vga outputs track fillscreen (x=0,y=0 colour 0; after 120 plots x=1 colour 1); exactly 19200 vga_plot cycles; ack[0] one-cycle pulse after done; busy low again.
- req=3'b111 held, all engines stub (done after 4 plots): grant order 0,1,2,0,… ; never the same engine twice consecutively; ack pulses once per run.
- Engine 1 running, engine 2 toggles eng_plot and eng_done continuously: vga_plot and vga_x/y reflect only engine 1; no ack[2].
- req[0] dropped mid-run: run continues to done, ack[0] still pulses; after return to IDLE with req=0, no restart.
- Engine holds done high 10 cycles after start drops: arbiter stays in RELEASE 10 cycles, vga_plot 0, no new eng_start until done falls.
- rst_n pulsed low mid-run (after 50 plots): eng_start, vga_plot, ack, busy 0 asynchronously; after release, req=3'b001 grants engine 0 first.
